// File: rtl/shiftreg_rx.sv
// Serial configuration-frame receiver: deserialises DYN then STAT words, commits on LATCH, flags framing errors.
// Optional SHIFTREG_RX_PARITY_EN appends an even-parity bit to each frame.
module shiftreg_rx #(
   parameter int DYN_W  = 16,
   parameter int STAT_W = 88,
   localparam int TOTAL = DYN_W + STAT_W,
   localparam int CNT_W = $clog2(TOTAL + 2)
) (
   input  logic              CLK,
   input  logic              RST_N,
   input  logic              FRAME_START,
   input  logic              SDI,
   input  logic              SDI_VALID,
   input  logic              LATCH,
   input  logic              ERR_CLR,
   output logic [DYN_W-1:0]  DYNLATCH_RX,
   output logic [STAT_W-1:0] STATLATCH_RX,
   output logic              FRAME_DONE,
   output logic              FRAME_ERR,
   output logic              BUSY,
   output logic [CNT_W-1:0]  BIT_CNT
);

`ifdef SHIFTREG_RX_PARITY_EN
   localparam int FLEN = TOTAL + 1;
`else
   localparam int FLEN = TOTAL;
`endif

   typedef enum logic [1:0] {IDLE, SHIFT, FULL} state_t;

   state_t          state, state_d;
   logic [FLEN-1:0] sreg;
   logic            clr, shift, commit, err_set, par_ok;

`ifdef SHIFTREG_RX_PARITY_EN
   assign par_ok = ~^sreg;
`else
   assign par_ok = 1'b1;
`endif

   always_comb begin
      state_d = state;
      clr     = 1'b0;
      shift   = 1'b0;
      commit  = 1'b0;
      err_set = 1'b0;
      case (state)
         IDLE: begin
            if (FRAME_START) begin
               state_d = SHIFT;
               clr     = 1'b1;
            end
         end
         SHIFT: begin
            if (FRAME_START) begin
               err_set = 1'b1;
               clr     = 1'b1;
            end else if (LATCH) begin
               err_set = 1'b1;
               state_d = IDLE;
            end else if (SDI_VALID) begin
               shift = 1'b1;
               if (BIT_CNT == CNT_W'(FLEN - 1)) state_d = FULL;
            end
         end
         FULL: begin
            // LATCH outranks both overrun and restart; a simultaneous FRAME_START chains the next frame
            if (LATCH) begin
               commit  = par_ok;
               err_set = ~par_ok;
               if (FRAME_START) begin
                  state_d = SHIFT;
                  clr     = 1'b1;
               end else begin
                  state_d = IDLE;
               end
            end else if (FRAME_START) begin
               err_set = 1'b1;
               clr     = 1'b1;
               state_d = SHIFT;
            end else if (SDI_VALID) begin
               err_set = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state        <= IDLE;
         sreg         <= '0;
         BIT_CNT      <= '0;
         DYNLATCH_RX  <= '0;
         STATLATCH_RX <= '0;
         FRAME_DONE   <= 1'b0;
         FRAME_ERR    <= 1'b0;
         BUSY         <= 1'b0;
      end else begin
         state      <= state_d;
         BUSY       <= (state_d != IDLE);
         FRAME_DONE <= commit;
         if (clr) begin
            sreg    <= '0;
            BIT_CNT <= '0;
         end else if (shift) begin
            sreg    <= {sreg[FLEN-2:0], SDI};
            BIT_CNT <= BIT_CNT + CNT_W'(1);
         end
         // parity bit, when present, sits in sreg[0] below the data
         if (commit) begin
            DYNLATCH_RX  <= sreg[FLEN-1 -: DYN_W];
            STATLATCH_RX <= sreg[FLEN-DYN_W-1 -: STAT_W];
         end
         if (err_set)      FRAME_ERR <= 1'b1;
         else if (ERR_CLR) FRAME_ERR <= 1'b0;
      end
   end

endmodule

// File: tb/tb_shiftreg_rx.sv
// Directed bench for shiftreg_rx: nominal, gapped, early latch, overrun, async reset, back-to-back, parity.
module tb_shiftreg_rx;
   localparam int DYN_W = 16, STAT_W = 88, TOTAL = DYN_W + STAT_W, CNT_W = $clog2(TOTAL + 2);
`ifdef SHIFTREG_RX_PARITY_EN
   localparam int FLEN = TOTAL + 1;
`else
   localparam int FLEN = TOTAL;
`endif

   logic              CLK = 1'b0, RST_N = 1'b0;
   logic              FRAME_START = 0, SDI = 0, SDI_VALID = 0, LATCH = 0, ERR_CLR = 0;
   logic [DYN_W-1:0]  DYNLATCH_RX;
   logic [STAT_W-1:0] STATLATCH_RX;
   logic              FRAME_DONE, FRAME_ERR, BUSY;
   logic [CNT_W-1:0]  BIT_CNT;

   int n_vec = 0, n_err = 0;

   logic [15:0] d1 = 16'hA5C3;
   logic [87:0] s1 = 88'h0123456789ABCDEF001122;
   logic [15:0] d2 = 16'h1234;
   logic [87:0] s2 = 88'hFEDCBA9876543210AA55CC;

   shiftreg_rx #(.DYN_W(DYN_W), .STAT_W(STAT_W)) dut (
      .CLK(CLK), .RST_N(RST_N), .FRAME_START(FRAME_START), .SDI(SDI), .SDI_VALID(SDI_VALID),
      .LATCH(LATCH), .ERR_CLR(ERR_CLR), .DYNLATCH_RX(DYNLATCH_RX), .STATLATCH_RX(STATLATCH_RX),
      .FRAME_DONE(FRAME_DONE), .FRAME_ERR(FRAME_ERR), .BUSY(BUSY), .BIT_CNT(BIT_CNT)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // frame image {dyn, stat, even-parity}; bit 104 goes out first
   function automatic logic [104:0] mkf(input logic [15:0] d, input logic [87:0] s);
      return {d, s, ^{d, s}};
   endfunction

   task automatic send(input logic [104:0] fv, input int n, input bit gap);
      for (int i = 0; i < n; i++) begin
         if (gap) begin
            SDI_VALID = 0;
            SDI = ~fv[104-i];
            tick();
         end
         SDI_VALID = 1;
         SDI = fv[104-i];
         tick();
      end
      SDI_VALID = 0;
      SDI = 0;
   endtask

   task automatic start();
      FRAME_START = 1;
      tick();
      FRAME_START = 0;
   endtask

   task automatic latch_commit(input string tag, input logic [15:0] d, input logic [87:0] s);
      LATCH = 1;
      tick();
      LATCH = 0;
      chk({tag, "_dyn"}, DYNLATCH_RX, d);
      chk({tag, "_stat"}, STATLATCH_RX, s);
      chk({tag, "_done"}, FRAME_DONE, 1);
      chk({tag, "_busy"}, BUSY, 0);
      chk({tag, "_err"}, FRAME_ERR, 0);
      tick();
      chk({tag, "_done_drop"}, FRAME_DONE, 0);
   endtask

   initial begin
      #3;
      chk("rst_dyn", DYNLATCH_RX, 0);
      chk("rst_stat", STATLATCH_RX, 0);
      chk("rst_done", FRAME_DONE, 0);
      chk("rst_err", FRAME_ERR, 0);
      chk("rst_busy", BUSY, 0);
      chk("rst_cnt", BIT_CNT, 0);
      @(negedge CLK);
      RST_N = 1;
      tick();

      // nominal
      start();
      chk("nom_busy0", BUSY, 1);
      chk("nom_cnt0", BIT_CNT, 0);
      send(mkf(d1, s1), FLEN, 0);
      chk("nom_cnt", BIT_CNT, FLEN);
      chk("nom_full_busy", BUSY, 1);
      latch_commit("nom", d1, s1);

      // gapped
      start();
      send(mkf(d1, s1), FLEN, 1);
      chk("gap_cnt", BIT_CNT, FLEN);
      latch_commit("gap", d1, s1);

      // early latch after 50 bits
      start();
      send(mkf(d2, s2), 50, 0);
      chk("early_cnt", BIT_CNT, 50);
      LATCH = 1;
      tick();
      LATCH = 0;
      chk("early_err", FRAME_ERR, 1);
      chk("early_dyn", DYNLATCH_RX, d1);
      chk("early_stat", STATLATCH_RX, s1);
      chk("early_busy", BUSY, 0);
      chk("early_done", FRAME_DONE, 0);

      // error clear, then overrun
      ERR_CLR = 1;
      tick();
      ERR_CLR = 0;
      chk("clr_err", FRAME_ERR, 0);
      start();
      send(mkf(d2, s2), FLEN, 0);
      chk("ovr_pre_err", FRAME_ERR, 0);
      SDI_VALID = 1;
      tick();
      SDI_VALID = 0;
      chk("ovr_err", FRAME_ERR, 1);
      chk("ovr_busy", BUSY, 0);
      chk("ovr_done", FRAME_DONE, 0);
      chk("ovr_dyn", DYNLATCH_RX, d1);
      ERR_CLR = 1;
      tick();
      ERR_CLR = 0;

      // asynchronous reset mid-frame
      start();
      send(mkf(d2, s2), 60, 0);
      chk("mid_cnt", BIT_CNT, 60);
      #2 RST_N = 0;
      #1;
      chk("arst_dyn", DYNLATCH_RX, 0);
      chk("arst_stat", STATLATCH_RX, 0);
      chk("arst_cnt", BIT_CNT, 0);
      chk("arst_busy", BUSY, 0);
      @(negedge CLK);
      RST_N = 1;
      tick();
      start();
      send(mkf(d2, s2), FLEN, 0);
      latch_commit("post_rst", d2, s2);

      // back-to-back: LATCH with FRAME_START in FULL
      start();
      send(mkf(d1, s1), FLEN, 0);
      LATCH = 1;
      FRAME_START = 1;
      tick();
      LATCH = 0;
      FRAME_START = 0;
      chk("b2b_done", FRAME_DONE, 1);
      chk("b2b_busy", BUSY, 1);
      chk("b2b_err", FRAME_ERR, 0);
      chk("b2b_cnt", BIT_CNT, 0);
      chk("b2b_dyn", DYNLATCH_RX, d1);
      send(mkf(d2, s2), FLEN, 0);
      latch_commit("b2b2", d2, s2);

`ifdef SHIFTREG_RX_PARITY_EN
      start();
      send(mkf(d1, s1) ^ 105'd1, FLEN, 0);
      LATCH = 1;
      tick();
      LATCH = 0;
      chk("par_err", FRAME_ERR, 1);
      chk("par_done", FRAME_DONE, 0);
      chk("par_dyn", DYNLATCH_RX, d2);
      chk("par_busy", BUSY, 0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
